// File: rtl/alu_pkg.sv
// Shared definitions for the alu sharing arbiter: FSM encoding and alu_fun codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] FUN_ADD  = 4'd0;
  localparam logic [3:0] FUN_SLL  = 4'd1;
  localparam logic [3:0] FUN_SLT  = 4'd2;
  localparam logic [3:0] FUN_SLTU = 4'd3;
  localparam logic [3:0] FUN_XOR  = 4'd4;
  localparam logic [3:0] FUN_SRL  = 4'd5;
  localparam logic [3:0] FUN_OR   = 4'd6;
  localparam logic [3:0] FUN_AND  = 4'd7;
  localparam logic [3:0] FUN_SUB  = 4'd8;
  localparam logic [3:0] FUN_LUI  = 4'd9;
  localparam logic [3:0] FUN_SRA  = 4'd13;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin grant; prio breaks ties only.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       gnt,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |valid;
    gnt     = 1'b0;
    if (valid == 2'b11) gnt = prio;
    else                gnt = valid[1];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational alu between the core (req 0) and debug (req 1)
// requesters; one operation in flight, result returned via a valid/ready response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FUN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_srcA,
  input  logic [WIDTH-1:0] req0_srcB,
  input  logic [FUN_W-1:0] req0_fun,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_srcA,
  input  logic [WIDTH-1:0] req1_srcB,
  input  logic [FUN_W-1:0] req1_fun,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [FUN_W-1:0] alu_fun,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             g_q, g_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [FUN_W-1:0] fun_q, fun_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic gnt, gnt_vld, accept, done;

  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .prio    (prio_q),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign accept = (state_q == IDLE) && gnt_vld;
  assign done   = (state_q == RESP) && (g_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      g_q      <= 1'b0;
      srca_q   <= '0;
      srcb_q   <= '0;
      fun_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      g_q      <= g_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      fun_q    <= fun_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prio_d   = prio_q;
    g_d      = g_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    fun_d    = fun_q;
    result_d = result_q;
    if (accept) begin
      g_d    = gnt;
      srca_d = gnt ? req1_srcA : req0_srcA;
      srcb_d = gnt ? req1_srcB : req0_srcB;
      fun_d  = gnt ? req1_fun  : req0_fun;
    end
    if (state_q == EXEC) result_d = alu_result;
    // The requester just served loses the next tie.
    if (done) prio_d = ~g_q;
  end

  always_comb begin
    req0_ready  = ~RST && accept && !gnt;
    req1_ready  = ~RST && accept &&  gnt;
    rsp0_valid  = (state_q == RESP) && !g_q;
    rsp1_valid  = (state_q == RESP) &&  g_q;
    rsp0_result = rsp0_valid ? result_q : '0;
    rsp1_result = rsp1_valid ? result_q : '0;
    busy        = (state_q != IDLE);
  end

  assign alu_srcA = srca_q;
  assign alu_srcB = srcb_q;
  assign alu_fun  = fun_q;

endmodule
